// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-SRAM responder and its storage bank.
package dmem_pkg;

    localparam int DW      = 64;
    localparam int BE_W    = 8;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The wait counter is 4 bits wide, which bounds the usable latency.
    function automatic bit latency_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// Request/response bundle between the execute stage (master) and the data SRAM (slave).
interface dsram_responder_if;
    import dmem_pkg::*;

    logic            data_sram_en;
    logic [BE_W-1:0] data_sram_we;
    logic [63:0]     data_sram_addr;
    logic [DW-1:0]   data_sram_wdata;
    logic [DW-1:0]   data_sram_rdata;
    logic            stallreq_dmem;
    logic            dmem_err;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq_dmem, dmem_err
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq_dmem, dmem_err
    );

endinterface

// File: rtl/dsram_bank.sv
// Single-port doubleword storage with byte-write enables and a registered read port.
module dsram_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [2**ADDR_W];

    // Array contents are deliberately left out of reset so this maps onto SRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM target: range decode, latency FSM with stall request, sticky error flag.
module dsram_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dsram_responder_if.slave   bus
);

    localparam logic [63:0] SPAN         = 64'd1 << (ADDR_W + 3);
    localparam logic [3:0]  CNT_INIT     = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit          SINGLE_CYCLE = (LATENCY == 1);

    generate
        if (!latency_ok(LATENCY)) begin : g_bad_latency
            $error("dsram_responder: LATENCY must be within 1..15");
        end
    endgenerate

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [BE_W-1:0]   we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DW-1:0]     wdata_q;
    logic              inr_q;
    logic              err_q;

    logic [63:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] index;

    logic              latch, commit, stall;
    logic [BE_W-1:0]   c_we;
    logic [ADDR_W-1:0] c_idx;
    logic [DW-1:0]     c_wdata;
    logic              c_inr;

    // Unsigned wrap makes addresses below the base land far outside the span.
    assign offset   = bus.data_sram_addr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign index    = offset[ADDR_W+2:3];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        latch   = 1'b0;
        commit  = 1'b0;
        c_we    = we_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_inr   = inr_q;
        case (state)
            IDLE: begin
                if (bus.data_sram_en) begin
                    if (SINGLE_CYCLE) begin
                        commit  = 1'b1;
                        c_we    = bus.data_sram_we;
                        c_idx   = index;
                        c_wdata = bus.data_sram_wdata;
                        c_inr   = in_range;
                    end else begin
                        stall   = 1'b1;
                        latch   = 1'b1;
                        cnt_n   = CNT_INIT;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    stall = 1'b1;
                    cnt_n = cnt - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request is captured on entry to WAIT because EX only promises to hold it, not to keep it stable for us.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            inr_q   <= 1'b0;
        end else if (latch) begin
            we_q    <= bus.data_sram_we;
            idx_q   <= index;
            wdata_q <= bus.data_sram_wdata;
            inr_q   <= in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (commit && !c_inr) begin
            err_q <= 1'b1;
        end
    end

    dsram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (commit && c_inr && (c_we != '0)),
        .rd_en   (commit && (c_we == '0)),
        .rd_zero (!c_inr),
        .be      (c_we),
        .idx     (c_idx),
        .wdata   (c_wdata),
        .rdata   (bus.data_sram_rdata)
    );

    assign bus.stallreq_dmem = stall;
    assign bus.dmem_err      = err_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder at latencies 1, 3 and 4 with hand-computed expectations.
module tb_dsram_responder;
    import dmem_pkg::*;

    localparam int          ADDR_W = 10;
    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SPAN   = 64'd1 << (ADDR_W + 3);
    localparam int          NVEC   = 22;

    localparam logic [63:0] D_FULL  = 64'h1122334455667788;
    localparam logic [63:0] D_MERGE = 64'h11223344_DEADBEEF;
    localparam logic [63:0] D_ZERO  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_LAST  = 64'hCAFEF00D_12345678;
    localparam logic [63:0] D_TOP   = 64'h55223344_DEADBEEF;

    logic clk = 1'b0;
    logic rst_n1, rst_n3, rst_n4;

    always #5 clk = ~clk;

    dsram_responder_if bus1();
    dsram_responder_if bus3();
    dsram_responder_if bus4();

    dsram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(bus1.slave)
    );
    dsram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(bus3.slave)
    );
    dsram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .bus(bus4.slave)
    );

    typedef struct {
        logic        en;
        logic [7:0]  we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic apply_stimulus(input int which, input logic en, input logic [7:0] we,
                                  input logic [63:0] addr, input logic [63:0] wdata);
        case (which)
            1: begin
                bus1.data_sram_en = en; bus1.data_sram_we = we;
                bus1.data_sram_addr = addr; bus1.data_sram_wdata = wdata;
            end
            3: begin
                bus3.data_sram_en = en; bus3.data_sram_we = we;
                bus3.data_sram_addr = addr; bus3.data_sram_wdata = wdata;
            end
            default: begin
                bus4.data_sram_en = en; bus4.data_sram_we = we;
                bus4.data_sram_addr = addr; bus4.data_sram_wdata = wdata;
            end
        endcase
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Rows are applied one per cycle; expected values are what the outputs show mid-cycle.
        vecs[0]  = '{1'b0, 8'h00, 64'h0,             64'h0,                 64'h0,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, BASE + 64'd8,      D_FULL,                64'h0,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, BASE + 64'd8,      64'h0,                 64'h0,   1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h0F, BASE + 64'd8,      64'hAAAAAAAA_DEADBEEF, D_FULL,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, BASE + 64'd8,      64'h0,                 D_FULL,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'hFF, BASE,              D_ZERO,                D_MERGE, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'hFF, BASE + SPAN - 8,   D_LAST,                D_MERGE, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, BASE + SPAN - 8,   64'h0,                 D_MERGE, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 64'h0,             64'h0,                 D_LAST,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h00, BASE + 64'd8,      64'h0,                 D_LAST,  1'b0, 1'b0};
        for (int i = 10; i < 15; i++) begin
            vecs[i] = '{1'b0, 8'h00, 64'h0, 64'h0, D_MERGE, 1'b0, 1'b0};
        end
        vecs[15] = '{1'b1, 8'h00, BASE - 64'd8,      64'h0,                 D_MERGE, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'hFF, BASE + SPAN,       64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h00, BASE,              64'h0,                 64'h0,   1'b0, 1'b1};
        vecs[18] = '{1'b1, 8'h00, BASE + 64'd8,      64'h0,                 D_ZERO,  1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'h80, BASE + 64'd8,      64'h5500_0000_0000_0000, D_MERGE, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 8'h00, BASE + 64'd8,      64'h0,                 D_MERGE, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 64'h0,             64'h0,                 D_TOP,   1'b0, 1'b1};

        rst_n1 = 1'b0; rst_n3 = 1'b0; rst_n4 = 1'b0;
        apply_stimulus(1, 1'b0, 8'h00, 64'h0, 64'h0);
        apply_stimulus(3, 1'b0, 8'h00, 64'h0, 64'h0);
        apply_stimulus(4, 1'b0, 8'h00, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n1 = 1'b1; rst_n3 = 1'b1; rst_n4 = 1'b1;

        // Single-cycle instance: table-driven
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(1, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            check_output($sformatf("lat1 row%0d rdata", i), bus1.data_sram_rdata, vecs[i].exp_rdata);
            check_output($sformatf("lat1 row%0d stall", i), 64'(bus1.stallreq_dmem), 64'(vecs[i].exp_stall));
            check_output($sformatf("lat1 row%0d err", i), 64'(bus1.dmem_err), 64'(vecs[i].exp_err));
            next_cycle();
        end

        // Sticky error clears only on reset
        @(negedge clk);
        rst_n1 = 1'b0;
        #1;
        check_output("lat1 reset err", 64'(bus1.dmem_err), 64'h0);
        check_output("lat1 reset rdata", bus1.data_sram_rdata, 64'h0);
        next_cycle();
        rst_n1 = 1'b1;
        @(negedge clk);
        check_output("lat1 post-reset err", 64'(bus1.dmem_err), 64'h0);
        next_cycle();

        // Latency 3: write then read with en held across the stall
        apply_stimulus(3, 1'b1, 8'hFF, BASE + 64'd24, 64'hFEDCBA98_76543210);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("lat3 wr stall%0d", k), 64'(bus3.stallreq_dmem), (k < 2) ? 64'h1 : 64'h0);
            check_output($sformatf("lat3 wr rdata%0d", k), bus3.data_sram_rdata, 64'h0);
            next_cycle();
        end
        apply_stimulus(3, 1'b0, 8'h00, 64'h0, 64'h0);
        @(negedge clk);
        check_output("lat3 wr done stall", 64'(bus3.stallreq_dmem), 64'h0);
        check_output("lat3 wr done rdata", bus3.data_sram_rdata, 64'h0);
        next_cycle();

        apply_stimulus(3, 1'b1, 8'h00, BASE + 64'd24, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("lat3 rd stall%0d", k), 64'(bus3.stallreq_dmem), (k < 2) ? 64'h1 : 64'h0);
            check_output($sformatf("lat3 rd rdata%0d", k), bus3.data_sram_rdata, 64'h0);
            next_cycle();
        end
        apply_stimulus(3, 1'b0, 8'h00, 64'h0, 64'h0);
        @(negedge clk);
        check_output("lat3 rd valid", bus3.data_sram_rdata, 64'hFEDCBA98_76543210);
        check_output("lat3 rd idle stall", 64'(bus3.stallreq_dmem), 64'h0);
        next_cycle();
        @(negedge clk);
        check_output("lat3 rd hold", bus3.data_sram_rdata, 64'hFEDCBA98_76543210);
        next_cycle();

        // Latency 4: seed BASE+16, then abort a second write with reset
        apply_stimulus(4, 1'b1, 8'hFF, BASE + 64'd16, 64'h0F0F0F0F_F0F0F0F0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("lat4 seed stall%0d", k), 64'(bus4.stallreq_dmem), (k < 3) ? 64'h1 : 64'h0);
            next_cycle();
        end
        apply_stimulus(4, 1'b0, 8'h00, 64'h0, 64'h0);
        next_cycle();

        apply_stimulus(4, 1'b1, 8'hFF, BASE + 64'd16, 64'hDEADDEAD_DEADDEAD);
        @(negedge clk);
        check_output("lat4 abort stall T", 64'(bus4.stallreq_dmem), 64'h1);
        next_cycle();
        @(negedge clk);
        check_output("lat4 abort stall T+1", 64'(bus4.stallreq_dmem), 64'h1);
        rst_n4 = 1'b0;
        apply_stimulus(4, 1'b0, 8'h00, 64'h0, 64'h0);
        #1;
        check_output("lat4 in-reset stall", 64'(bus4.stallreq_dmem), 64'h0);
        check_output("lat4 in-reset rdata", bus4.data_sram_rdata, 64'h0);
        next_cycle();
        rst_n4 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("lat4 post-reset stall", 64'(bus4.stallreq_dmem), 64'h0);
            next_cycle();
        end

        apply_stimulus(4, 1'b1, 8'h00, BASE + 64'd16, 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("lat4 rd stall%0d", k), 64'(bus4.stallreq_dmem), (k < 3) ? 64'h1 : 64'h0);
            check_output($sformatf("lat4 rd rdata%0d", k), bus4.data_sram_rdata, 64'h0);
            next_cycle();
        end
        apply_stimulus(4, 1'b0, 8'h00, 64'h0, 64'h0);
        @(negedge clk);
        check_output("lat4 pre-write contents", bus4.data_sram_rdata, 64'h0F0F0F0F_F0F0F0F0);
        check_output("lat4 err", 64'(bus4.dmem_err), 64'h0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Target side of the data-SRAM interface driven by the execute stage.
- Accepts the en/we/addr/wdata request, performs a byte-enabled 64-bit access on an internal storage bank, and returns registered read data for the MEM stage.
- Models configurable memory latency. For latency above 1 it holds the pipeline through a stall request feeding the stall controller.

Parameters:
- ADDR_W, 10, log2 of bank depth in doublewords (depth = 2^ADDR_W).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte base address of the bank.
- LATENCY, 1, access latency in cycles, 1..15; LATENCY-1 stall cycles per access.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- data_sram_en  in  1  request valid.
- data_sram_we  in  8  byte write enables; nonzero = write, zero = read.
- data_sram_addr  in  64  byte address; bits [2:0] ignored.
- data_sram_wdata  in  64  write data, byte lanes aligned to we.
- data_sram_rdata  out  64  registered read data.
- stallreq_dmem  out  1  pipeline stall request, combinational from state and en.
- dmem_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (async assert):
  - state=IDLE, cnt=0, data_sram_rdata=0, stallreq_dmem=0, dmem_err=0.
  - Any pending access is dropped, and a pending write never commits.
  - Bank contents are not reset.
- Decode: in_range = (addr - BASE_ADDR) < 2^(ADDR_W+3), compared as unsigned 64-bit. index = (addr - BASE_ADDR)[ADDR_W+2:3].
- States: IDLE, WAIT. cnt is 4 bits.
- IDLE with en=1, LATENCY==1:
  - No stall.
  - The access commits at this cycle's edge.
  - For a read, rdata is valid the next cycle.
- IDLE with en=1, LATENCY>1:
  - stallreq_dmem=1 this cycle.
  - Latch we/index/wdata/in_range.
  - cnt<=LATENCY-2; go to WAIT.
- WAIT:
  - stallreq_dmem = (cnt!=0).
  - If cnt!=0, cnt decrements.
  - If cnt==0, commit the latched access at this edge and return to IDLE.
  - en and request inputs are ignored while in WAIT (EX holds them during the stall).
- Overall timing: for a request first seen at cycle T, stall is high for T..T+LATENCY-2 and read data is valid at T+LATENCY.
- Commit, write: for each i with we[i]=1, bank byte i = wdata[8i+7:8i]. Other bytes are unchanged. rdata holds its previous value.
- Commit, read: rdata <= bank[index] (full doubleword; MEM stage selects and extends).
- Commit, out of range:
  - Writes are dropped.
  - A read returns 64'h0.
  - dmem_err<=1, and it stays set until reset.
- Hold rule: rdata changes only on a read commit and is held stable across stalls and idle cycles.
- Back-to-back (LATENCY==1): a read in cycle T+1 of the address written in cycle T returns the new data at T+2. Bank write-then-read ordering is guaranteed by commit order.
- In IDLE with en=0: nothing changes, stall=0.

Decomposition:
- Shared package (dmem_pkg):
  - state encoding: IDLE=1'b0, WAIT=1'b1;
  - DW=64, BE_W=8;
  - the LATENCY range check constant (assertion: 1<=LATENCY<=15).
- Sub-module dsram_bank:
  - 2^ADDR_W x 64 synchronous array;
  - one port, with byte-write enables and a registered read output;
  - read data is captured only when rd_en.
- dsram_responder contains the FSM, counter, request latch, range decode, error flag and stall logic.

Test Plan:
- LATENCY=1, rst_n 0→1.
  - Write we=8'hFF addr=BASE+8 wdata=64'h1122334455667788.
  - Read the same address the next cycle → rdata=64'h1122334455667788 one cycle later; stallreq_dmem never 1.
- Byte merge (LATENCY=1), starting from the previous state.
  - Write we=8'h0F wdata=64'hAAAAAAAA_DEADBEEF to BASE+8.
  - Read BASE+8 → 64'h11223344_DEADBEEF; rdata is unchanged in the write's result cycle.
- LATENCY=3, read issued at T with en held during the stall → stallreq_dmem=1 at T and T+1, 0 at T+2; rdata valid at T+3; exactly one commit.
- Out-of-range (LATENCY=1):
  - Read at BASE-8 → rdata=0, dmem_err=1.
  - A following write at BASE+2^(ADDR_W+3) leaves the bank unchanged.
  - dmem_err stays 1 until rst_n=0.
- Reset mid-operation (LATENCY=4):
  - Write to BASE+16 issued; rst_n pulsed low during WAIT.
  - Afterwards state=IDLE, stall=0, rdata=0, and reading BASE+16 returns the pre-write contents.
- Idle hold: read BASE+8, then 5 cycles of en=0 → rdata stays 64'h11223344_DEADBEEF and stallreq_dmem=0 throughout.
